// File: rtl/repair_chain_tx.sv
// Serialises four repair addresses into the repair/fuse register chain over a valid/ready bit stream, then strobes latch.
// Build option REPAIR_CHAIN_PARITY_EN appends an even-parity bit after each slot's address LSB.

module repair_chain_slot #(
    parameter int ADDR_W = 10,
    parameter int SW     = ADDR_W + 1
) (
    input  logic              vld,
    input  logic [ADDR_W-1:0] addr,
    output logic [SW-1:0]     bits
);
    logic [ADDR_W-1:0] addr_m;

    // Invalid slots carry an all-zero payload regardless of the address input.
    assign addr_m = vld ? addr : '0;

`ifdef REPAIR_CHAIN_PARITY_EN
    assign bits = {vld, addr_m, ^{vld, addr_m}};
`else
    assign bits = {vld, addr_m};
`endif
endmodule

module repair_chain_tx #(
    parameter int ADDR_W = 10,
    parameter int NSLOT  = 4,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] repair_addr1,
    input  logic [ADDR_W-1:0] repair_addr2,
    input  logic [ADDR_W-1:0] repair_addr3,
    input  logic [ADDR_W-1:0] repair_addr4,
    input  logic [NSLOT-1:0]  repair_vld,
    output logic              busy,
    output logic              s_valid,
    output logic              s_data,
    input  logic              s_ready,
    output logic              s_latch,
    output logic              done,
    output logic [2:0]        rep_cnt
);
`ifdef REPAIR_CHAIN_PARITY_EN
    localparam int SW = ADDR_W + 2;
`else
    localparam int SW = ADDR_W + 1;
`endif
    localparam int TB = NSLOT * SW;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    typedef struct packed {
        logic       busy;
        logic       s_valid;
        logic       s_latch;
        logic       done;
        logic [2:0] rep_cnt;
    } out_t;

    state_t                        state_q, state_d;
    out_t                          out_q, out_d;
    logic [TB-1:0]                 sr_q, sr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NSLOT-1:0][ADDR_W-1:0]  addr_bus;
    logic [NSLOT-1:0][SW-1:0]      slot_bits;
    logic [2:0]                    pop;

    assign addr_bus = {repair_addr4, repair_addr3, repair_addr2, repair_addr1};

    // Slot 1 lands in the top element so the flattened frame leaves MSB-first in slot order.
    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        repair_chain_slot #(.ADDR_W(ADDR_W), .SW(SW)) u_slot (
            .vld  (repair_vld[g]),
            .addr (addr_bus[g]),
            .bits (slot_bits[NSLOT-1-g])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NSLOT; i++) pop = pop + 3'(repair_vld[i]);
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_d.s_latch = 1'b0;
        out_d.done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = SHIFT;
                    sr_d            = slot_bits;
                    cnt_d           = '0;
                    out_d.busy      = 1'b1;
                    out_d.s_valid   = 1'b1;
                    out_d.rep_cnt   = pop;
                end
            end
            SHIFT: begin
                if (out_q.s_valid && s_ready) begin
                    sr_d  = {sr_q[TB-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TB - 1)) begin
                        state_d       = LATCH;
                        out_d.s_valid = 1'b0;
                        out_d.s_latch = 1'b1;
                        out_d.done    = 1'b1;
                    end
                end
            end
            LATCH: begin
                state_d    = IDLE;
                out_d.busy = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign busy    = out_q.busy;
    assign s_valid = out_q.s_valid;
    assign s_latch = out_q.s_latch;
    assign done    = out_q.done;
    assign rep_cnt = out_q.rep_cnt;
    assign s_data  = sr_q[TB-1];
endmodule

// File: tb/tb_repair_chain_tx.sv
// Directed + randomized bench for repair_chain_tx against a bit-list frame model.
module tb_repair_chain_tx;
    localparam int ADDR_W = 10;
    localparam int NSLOT  = 4;
`ifdef REPAIR_CHAIN_PARITY_EN
    localparam int SW = ADDR_W + 2;
`else
    localparam int SW = ADDR_W + 1;
`endif
    localparam int TB = NSLOT * SW;

    logic        clk = 1'b0;
    logic        rst, start, s_ready;
    logic [9:0]  a1, a2, a3, a4;
    logic [3:0]  vld;
    logic        busy, s_valid, s_data, s_latch, done;
    logic [2:0]  rep_cnt;
    logic [63:0] got;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    repair_chain_tx #(.ADDR_W(ADDR_W), .NSLOT(NSLOT), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .repair_addr1(a1), .repair_addr2(a2), .repair_addr3(a3), .repair_addr4(a4),
        .repair_vld(vld), .busy(busy), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .s_latch(s_latch), .done(done), .rep_cnt(rep_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: each slot is its valid bit, then its address MSB..LSB (zeroed when invalid),
    // optionally followed by a bit that makes the slot's count of ones even.
    function automatic logic [63:0] exp_frame(input logic [3:0] v, input logic [39:0] av);
        logic [63:0] f = '0;
        for (int s = 0; s < NSLOT; s++) begin
            int ones = 0;
            logic vb = v[s];
            f = {f[62:0], vb};
            ones += int'(vb);
            for (int b = ADDR_W - 1; b >= 0; b--) begin
                logic ab = vb ? av[s*ADDR_W + b] : 1'b0;
                f = {f[62:0], ab};
                ones += int'(ab);
            end
`ifdef REPAIR_CHAIN_PARITY_EN
            f = {f[62:0], 1'(ones % 2)};
`endif
        end
        return f;
    endfunction

    function automatic int popc(input logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"},    64'(busy),    64'(0));
        chk({tag, ".s_valid"}, 64'(s_valid), 64'(0));
        chk({tag, ".s_data"},  64'(s_data),  64'(0));
        chk({tag, ".s_latch"}, 64'(s_latch), 64'(0));
        chk({tag, ".done"},    64'(done),    64'(0));
        chk({tag, ".rep_cnt"}, 64'(rep_cnt), 64'(0));
    endtask

    // mode 0: always ready; 1: 3-cycle stalls at bits 0, 10, TB-1; 2: random ready
    task automatic run_frame(input string name, input logic [3:0] v, input logic [39:0] av,
                             input int mode, input int start_at, input int rst_at,
                             output logic [63:0] got_o);
        logic [63:0] expv;
        logic [63:0] g = '0;
        int nbits = 0, stalls = 0, busy_cyc = 0, latch_cnt = 0, done_cnt = 0;
        int dmis = 0, unstable = 0, stall_left = 0, stalled_for = -1, cyc = 0, latch_cyc = 0;
        int idle_bad = 0;
        logic prev_stall = 1'b0, prev_data = 1'b0;
        bit fin = 1'b0, start_used = 1'b0;
        expv = exp_frame(v, av);
        got_o = '0;
        @(negedge clk);
        vld = v; {a4, a3, a2, a1} = av; start = 1'b1; s_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ".busy_first"},  64'(busy),    64'(1));
        chk({name, ".valid_first"}, 64'(s_valid), 64'(1));
        while (cyc < 400) begin
            if (latch_cnt > 0) begin
                chk({name, ".busy_after_latch"},  64'(busy),    64'(0));
                chk({name, ".latch_after_latch"}, 64'(s_latch), 64'(0));
                fin = 1'b1;
                break;
            end
            cyc++;
            {a4, a3, a2, a1} = 40'({$urandom(), $urandom()});
            vld = 4'($urandom());
            if (rst_at >= 0 && nbits == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_reset_outputs({name, ".rst_mid"});
                chk({name, ".no_latch_before_rst"}, 64'(latch_cnt), 64'(0));
                repeat (4) begin
                    @(negedge clk);
                    if (busy || s_valid || s_latch || done) idle_bad++;
                end
                chk({name, ".quiet_after_rst"}, 64'(idle_bad), 64'(0));
                return;
            end
            start = 1'b0;
            if (start_at >= 0 && nbits == start_at && !start_used) begin
                start = 1'b1;
                start_used = 1'b1;
            end
            if (mode == 1 && s_valid && (nbits == 0 || nbits == 10 || nbits == TB - 1)
                && stalled_for != nbits) begin
                stall_left = 3;
                stalled_for = nbits;
            end
            s_ready = (mode == 2) ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (busy) busy_cyc++;
            if (done !== s_latch) dmis++;
            if (done) done_cnt++;
            if (s_latch) begin
                latch_cnt++;
                latch_cyc = cyc;
                chk({name, ".bits_at_latch"}, 64'(nbits), 64'(TB));
            end
            if (prev_stall && (s_data !== prev_data || s_valid !== 1'b1)) unstable++;
            if (s_valid && s_ready) begin
                g = {g[62:0], s_data};
                nbits++;
            end
            prev_stall = s_valid && !s_ready;
            prev_data = s_data;
            if (prev_stall) stalls++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, ".finished"}, 64'(fin), 64'(1));
        chk({name, ".nbits"},    64'(nbits), 64'(TB));
        chk({name, ".frame"},    g, expv);
        chk({name, ".latches"},  64'(latch_cnt), 64'(1));
        chk({name, ".dones"},    64'(done_cnt), 64'(1));
        chk({name, ".done_eq_latch"}, 64'(dmis), 64'(0));
        chk({name, ".stall_hold"},    64'(unstable), 64'(0));
        chk({name, ".busy_cycles"},   64'(busy_cyc), 64'(TB + stalls + 1));
        chk({name, ".latch_cycle"},   64'(latch_cyc), 64'(TB + stalls + 1));
        if (mode == 1) chk({name, ".stall_count"}, 64'(stalls), 64'(9));
        chk({name, ".rep_cnt"}, 64'(rep_cnt), 64'(popc(v)));
        repeat (4) begin
            @(negedge clk);
            if (busy || s_valid || s_latch || done) idle_bad++;
        end
        chk({name, ".idle_after"},  64'(idle_bad), 64'(0));
        chk({name, ".rep_cnt_held"}, 64'(rep_cnt), 64'(popc(v)));
        got_o = g;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_ready = 1'b0; vld = '0;
        a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // reset beats a simultaneous start
        start = 1'b1;
        @(negedge clk);
        chk("rst_start.busy", 64'(busy), 64'(0));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start.valid", 64'(s_valid), 64'(0));

        run_frame("t1_full", 4'b1111, {10'h2AA, 10'h155, 10'h000, 10'h3FF}, 0, -1, -1, got);
`ifndef REPAIR_CHAIN_PARITY_EN
        chk("t1_full.const_frame", got,
            64'({1'b1, 10'h3FF, 1'b1, 10'h000, 1'b1, 10'h155, 1'b1, 10'h2AA}));
`endif
        run_frame("t2_sparse", 4'b0101,
                  {10'h3FF, 10'($urandom()), 10'h3FF, 10'($urandom())}, 0, -1, -1, got);
        run_frame("t3_stall", 4'b1111, 40'({$urandom(), $urandom()}), 1, -1, -1, got);
        run_frame("t4_restart", 4'b1011, 40'({$urandom(), $urandom()}), 0, 20, -1, got);
        run_frame("t5_rst", 4'b1111, 40'({$urandom(), $urandom()}), 0, -1, 15, got);
        run_frame("t5_fresh", 4'b0110, 40'({$urandom(), $urandom()}), 2, -1, -1, got);
        run_frame("t6_slot1", 4'b0001, {10'h3FF, 10'h3FF, 10'h3FF, 10'h001}, 0, -1, -1, got);
`ifdef REPAIR_CHAIN_PARITY_EN
        chk("t6_slot1.parity_slot", got[47:36], 64'(12'b1_0000000001_0));
`endif
        for (int i = 0; i < 6; i++)
            run_frame("rand", 4'($urandom()), 40'({$urandom(), $urandom()}), 2, -1, -1, got);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/repair_chain_tx.md
Name: repair_chain_tx

Overview:
- Takes the four repair addresses from the RC mux stage (slot 1 to slot 4) and their per-slot valid flags.
- Serialises them, bit by bit, into the repair/fuse register chain of the memory array.
- Uses a valid/ready handshake toward the chain and pulses a latch strobe once the full frame has been accepted.
- Sits between redundancy analysis and the repair register chain. It is the write side of the chain interface.

Parameters:
ADDR_W, 10, width of one repair address
NSLOT, 4, number of repair slots per frame
CNT_W, 6, width of the bit counter; must hold NSLOT*(ADDR_W+2)-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to transmit one frame; sampled only in IDLE
repair_addr1  input  ADDR_W  slot 1 address
repair_addr2  input  ADDR_W  slot 2 address
repair_addr3  input  ADDR_W  slot 3 address
repair_addr4  input  ADDR_W  slot 4 address
repair_vld  input  NSLOT  per-slot valid; bit 0 = slot 1
busy  output  1  high from the cycle after start is accepted until the latch cycle ends
s_valid  output  1  s_data is valid this cycle
s_data  output  1  serial chain bit
s_ready  input  1  chain accepts the bit when s_valid && s_ready
s_latch  output  1  one-cycle strobe: chain contents complete
done  output  1  one-cycle pulse, coincident with s_latch
rep_cnt  output  3  popcount of repair_vld captured at start; held until the next start

Behaviour:
- All outputs are registered. Interface fixed: one clock, clk; synchronous active-high reset, rst.
- Reset values: busy=0, s_valid=0, s_data=0, s_latch=0, done=0, rep_cnt=0, state=IDLE, counter=0.
- Slot frame, MSB first: valid bit, then addr[ADDR_W-1:0]. Slot width SW=ADDR_W+1, i.e. 11.
- Full frame order: slot 1, slot 2, slot 3, slot 4. Total bits TB=NSLOT*SW, i.e. 44.
- An invalid slot still transmits its valid bit = 0. Its address bits are forced to 0, whatever is on repair_addrN.
- State IDLE:
  - start=1 at edge T: capture the full frame into the shift register, set rep_cnt, counter=0, go to SHIFT.
  - From edge T: busy=1, s_valid=1, s_data = first bit, which is slot 1's valid bit.
- State SHIFT:
  - On each edge where s_valid && s_ready: shift left, counter++.
  - When the accepted bit is number TB-1: s_valid=0, go to LATCH.
  - With s_ready=0: hold s_data and s_valid unchanged, with no limit on stall length.
- State LATCH: s_latch=1 and done=1 for exactly one cycle, then go to IDLE. busy=0 from the following edge.
- Latency with s_ready tied to 1: start at T gives first bit valid after T; last bit accepted at edge T+TB; s_latch high in the cycle after that edge.
- start while busy: ignored. No queueing. Inputs are not resampled.
- start and rst in the same cycle: reset wins.
- rst mid-frame: return to IDLE with reset values. No s_latch or done pulse. The chain contents are undefined, and a new frame is required.
- repair_addrN and repair_vld only matter in the capture cycle. Changes during SHIFT have no effect.
- counter is CNT_W bits. Counter wrap is not possible for legal parameter values.

Optional Feature:
Macro REPAIR_CHAIN_PARITY_EN
- Defined:
  - An even-parity bit is appended after each slot's address LSB. It covers the valid bit plus the address bits.
  - SW=ADDR_W+2, so TB=48 by default.
  - An invalid slot sends parity 0.
- Undefined: no parity bit; SW=ADDR_W+1, TB=44.
- Both builds use the same ports.

Test Plan:
1. All valid, no backpressure.
   - Stimulus: repair_vld=4'b1111; addr1=10'h3FF, addr2=10'h000, addr3=10'h155, addr4=10'h2AA; s_ready=1; start one cycle.
   - Required response: exactly 44 accepted bits, frame 1_1111111111 1_0000000000 1_0101010101 1_1010101010; s_latch and done high for 1 cycle right after the 44th bit; rep_cnt=4.
2. Sparse slots.
   - Stimulus: repair_vld=4'b0101; addr2=10'h3FF, addr4=10'h3FF.
   - Required response: slots 2 and 4 send 0_0000000000; rep_cnt=2.
3. Backpressure.
   - Stimulus: s_ready low for 3 cycles at bit 0, bit 10 and bit 43.
   - Required response: s_data stable during each stall; 44 accepted bits; s_latch only after the last accept; busy high for 44+9+1 cycles.
4. Start while busy and input changes.
   - Stimulus: pulse start at bit 20; change repair_addr1 during SHIFT.
   - Required response: no restart; transmitted frame unchanged; exactly one done.
5. Reset mid-frame.
   - Stimulus: assert rst at bit 15, then issue a fresh start.
   - Required response: all outputs at reset values the next cycle; no s_latch; the new frame completes correctly from bit 0.
6. Parity build (REPAIR_CHAIN_PARITY_EN).
   - Stimulus: addr1=10'h001, vld=1.
   - Required response: slot 1 sends 1_0000000001_0; 48 bits total.
